// File: rtl/vector_index_sequencer_pkg.sv
// Shared types and width helpers for the vector index sequencer.
package vector_index_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // A modulus of 1 still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_index_sequencer_if.sv
// Beat handshake plus index/flag outputs between the vector source, sequencer and MAC logic.
interface vector_index_sequencer_if #(
  parameter int EIDX_W = 2,
  parameter int VIDX_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [EIDX_W-1:0] elem_index;
  logic [VIDX_W-1:0] vec_index;
  logic              last_elem;
  logic              last_vec;
  logic              restart_counter;
  logic              batch_done;
  logic              busy;

  modport master (
    output in_valid,
    input  in_ready, elem_index, vec_index, last_elem, last_vec,
           restart_counter, batch_done, busy
  );

  modport slave (
    input  in_valid,
    output in_ready, elem_index, vec_index, last_elem, last_vec,
           restart_counter, batch_done, busy
  );
endinterface

// File: rtl/vector_index_sequencer_counter.sv
// Modulo-MOD up-counter with synchronous clear; wraps at MOD-1, not at 2^W.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);
  localparam logic [W-1:0] CNT_MAX = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CNT_MAX);
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = at_max_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vector_index_sequencer.sv
// Two-level element/vector index sequencer advanced by accepted input beats,
// with wrap or one-shot batch modes.
module vector_index_sequencer
  import vector_index_sequencer_pkg::*;
#(
  parameter int VEC_LEN     = 4,
  parameter int NUM_VECTORS = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic mode_oneshot_i,
  vector_index_sequencer_if.slave bus
);
  localparam int EIDX_W = clog2_min1(VEC_LEN);
  localparam int VIDX_W = clog2_min1(NUM_VECTORS);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  if (VEC_LEN < 1 || NUM_VECTORS < 1) begin : g_param_check
    $error("vector_index_sequencer: VEC_LEN and NUM_VECTORS must be >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic              batch_done_q, batch_done_d;
  logic              busy_q, busy_d;
  logic              in_ready, beat, final_beat;
  logic              last_elem, last_vec;
  logic [EIDX_W-1:0] elem_cnt;
  logic [VIDX_W-1:0] vec_cnt;

  assign in_ready   = en_i && (state_q == ST_RUN) && !clear_i;
  assign beat       = bus.in_valid && in_ready;
  assign final_beat = beat && last_elem && last_vec;

  mod_counter #(.MOD(VEC_LEN), .W(EIDX_W)) u_elem_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (beat),
    .clr_i    (clear_i),
    .cnt_o    (elem_cnt),
    .at_max_o (last_elem)
  );

  mod_counter #(.MOD(NUM_VECTORS), .W(VIDX_W)) u_vec_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (beat && last_elem),
    .clr_i    (clear_i),
    .cnt_o    (vec_cnt),
    .at_max_o (last_vec)
  );

  // Indices are already zero on entry to DONE (final beat wraps them), so no extra clear.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else if (en_i) begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN:  if (final_beat && mode_oneshot_i) state_d = ST_DONE;
        ST_DONE: if (start_i) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign batch_done_d = final_beat;
  assign busy_d       = (state_d == ST_RUN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      batch_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      batch_done_q <= batch_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.elem_index      = elem_cnt;
  assign bus.vec_index       = vec_cnt;
  assign bus.last_elem       = last_elem;
  assign bus.last_vec        = last_vec;
  assign bus.restart_counter = clear_i || final_beat;
  assign bus.batch_done      = batch_done_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_vector_index_sequencer.sv
// Self-checking bench: three sequencer configurations (4x2, 3x5, 1x1) share one stimulus
// stream and are checked against a position-counting reference model.
module tb_vector_index_sequencer;
  logic clk, rst, en, clr, start, mode, valid;

  int n_vec = 0;
  int n_err = 0;

  int L[3] = '{4, 3, 1};
  int N[3] = '{2, 5, 1};
  // Model: state 0=idle 1=run 2=done; pos = beats accepted in the current batch.
  int m_state[3];
  int m_pos[3];
  bit m_bd[3];

  vector_index_sequencer_if #(.EIDX_W(2), .VIDX_W(1)) if0 ();
  vector_index_sequencer_if #(.EIDX_W(2), .VIDX_W(3)) if1 ();
  vector_index_sequencer_if #(.EIDX_W(1), .VIDX_W(1)) if2 ();

  assign if0.in_valid = valid;
  assign if1.in_valid = valid;
  assign if2.in_valid = valid;

  vector_index_sequencer #(.VEC_LEN(4), .NUM_VECTORS(2)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .start_i(start),
    .mode_oneshot_i(mode), .bus(if0.slave));
  vector_index_sequencer #(.VEC_LEN(3), .NUM_VECTORS(5)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .start_i(start),
    .mode_oneshot_i(mode), .bus(if1.slave));
  vector_index_sequencer #(.VEC_LEN(1), .NUM_VECTORS(1)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .start_i(start),
    .mode_oneshot_i(mode), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0; m_pos[k] = 0; m_bd[k] = 1'b0;
    end
  endfunction

  // Advance the model over one rising edge using the inputs held during that cycle.
  function automatic void model_update();
    for (int k = 0; k < 3; k++) begin
      int total = L[k] * N[k];
      bit rdy   = en && (m_state[k] == 1) && !clr;
      bit bt    = valid && rdy;
      bit fin   = bt && (m_pos[k] == total - 1);
      if (clr) begin
        m_state[k] = 0; m_pos[k] = 0; m_bd[k] = 1'b0;
      end else begin
        m_bd[k] = fin;
        if (bt) m_pos[k] = (m_pos[k] + 1) % total;
        if (en) begin
          if (m_state[k] == 0 && start) m_state[k] = 1;
          else if (m_state[k] == 1 && fin && mode) m_state[k] = 2;
          else if (m_state[k] == 2 && start) m_state[k] = 1;
        end
      end
    end
  endfunction

  // {elem[3:0], vec[3:0], last_elem, last_vec, in_ready, restart, busy, batch_done, 2'b0}
  function automatic logic [15:0] expv(int k);
    int e    = m_pos[k] % L[k];
    int v    = m_pos[k] / L[k];
    bit rdy  = en && (m_state[k] == 1) && !clr;
    bit rst_c = clr || (valid && rdy && (m_pos[k] == L[k] * N[k] - 1));
    return {4'(e), 4'(v), (e == L[k] - 1), (v == N[k] - 1), rdy, rst_c,
            (m_state[k] == 1), m_bd[k], 2'b00};
  endfunction

  function automatic logic [15:0] obs(int k);
    case (k)
      0: return {4'(if0.elem_index), 4'(if0.vec_index), if0.last_elem, if0.last_vec,
                 if0.in_ready, if0.restart_counter, if0.busy, if0.batch_done, 2'b00};
      1: return {4'(if1.elem_index), 4'(if1.vec_index), if1.last_elem, if1.last_vec,
                 if1.in_ready, if1.restart_counter, if1.busy, if1.batch_done, 2'b00};
      default: return {4'(if2.elem_index), 4'(if2.vec_index), if2.last_elem, if2.last_vec,
                 if2.in_ready, if2.restart_counter, if2.busy, if2.batch_done, 2'b00};
    endcase
  endfunction

  task automatic apply(input bit e, input bit c, input bit s, input bit m, input bit v);
    @(negedge clk);
    model_update();
    en = e; clr = c; start = s; mode = m; valid = v;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; en = 0; clr = 0; start = 0; mode = 0; valid = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; clr = 0; start = 0; mode = 0; valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== expv(k)) begin
        n_err++; $display("FAIL reset dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    n_vec++;
    if ({if0.busy, if0.batch_done, if0.elem_index} !== 4'b0000) begin
      n_err++; $display("FAIL reset_zero got %b want 0000", {if0.busy, if0.batch_done, if0.elem_index});
    end
  endtask

  task automatic test_wrap();
    apply(1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(1, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== expv(k)) begin
          n_err++; $display("FAIL wrap beat%0d dut%0d got %h want %h", i, k, obs(k), expv(k));
        end
      end
      n_vec++;
      if ({if0.elem_index, if0.vec_index, if0.restart_counter} !== {2'(i % 4), 1'(i / 4), (i == 7)}) begin
        n_err++;
        $display("FAIL wrap_seq beat%0d got e%0d v%0d r%0d want e%0d v%0d r%0d", i,
                 if0.elem_index, if0.vec_index, if0.restart_counter, i % 4, i / 4, (i == 7));
      end
    end
    apply(1, 0, 0, 0, 0);
    n_vec++;
    if ({if0.batch_done, if0.busy, if0.elem_index, if0.vec_index} !== 5'b11000) begin
      n_err++; $display("FAIL wrap_done got %b want 11000",
                        {if0.batch_done, if0.busy, if0.elem_index, if0.vec_index});
    end
  endtask

  task automatic test_oneshot();
    pulse_reset();
    apply(1, 0, 1, 1, 0);
    for (int i = 0; i < 11; i++) begin
      apply(1, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== expv(k)) begin
          n_err++; $display("FAIL oneshot cyc%0d dut%0d got %h want %h", i, k, obs(k), expv(k));
        end
      end
    end
    n_vec++;
    if ({if0.in_ready, if0.busy, if0.elem_index, if0.vec_index} !== 5'b00000) begin
      n_err++; $display("FAIL oneshot_hold got %b want 00000",
                        {if0.in_ready, if0.busy, if0.elem_index, if0.vec_index});
    end
    apply(1, 0, 1, 1, 1);
    apply(1, 0, 0, 1, 1);
    apply(1, 0, 0, 1, 0);
    n_vec++;
    if ({if0.busy, if0.elem_index} !== 3'b101) begin
      n_err++; $display("FAIL oneshot_restart got busy%0d e%0d want busy1 e1", if0.busy, if0.elem_index);
    end
  endtask

  task automatic test_toggle();
    int bd_cnt = 0, max_e = 0, max_v = 0;
    pulse_reset();
    apply(1, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      apply(1, 0, 0, 0, (i % 2) == 0);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== expv(k)) begin
          n_err++; $display("FAIL toggle cyc%0d dut%0d got %h want %h", i, k, obs(k), expv(k));
        end
      end
      if (if1.batch_done) bd_cnt++;
      if (int'(if1.elem_index) > max_e) max_e = int'(if1.elem_index);
      if (int'(if1.vec_index) > max_v) max_v = int'(if1.vec_index);
    end
    n_vec++;
    if (bd_cnt != 1 || max_e != 2 || max_v != 4 || if1.vec_index !== 3'd0) begin
      n_err++; $display("FAIL toggle_3x5 got bd%0d maxe%0d maxv%0d v%0d want bd1 maxe2 maxv4 v0",
                        bd_cnt, max_e, max_v, if1.vec_index);
    end
  endtask

  task automatic test_en_freeze();
    pulse_reset();
    apply(1, 0, 1, 0, 0);
    repeat (6) apply(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== expv(k)) begin
          n_err++; $display("FAIL freeze cyc%0d dut%0d got %h want %h", i, k, obs(k), expv(k));
        end
      end
      n_vec++;
      if ({if0.in_ready, if0.elem_index, if0.vec_index} !== 4'b0101) begin
        n_err++; $display("FAIL freeze_hold got %b want 0101", {if0.in_ready, if0.elem_index, if0.vec_index});
      end
    end
    apply(1, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0);
    n_vec++;
    if ({if0.elem_index, if0.vec_index} !== 3'b111) begin
      n_err++; $display("FAIL freeze_resume got e%0d v%0d want e3 v1", if0.elem_index, if0.vec_index);
    end
  endtask

  task automatic test_clear();
    pulse_reset();
    apply(1, 0, 1, 0, 0);
    repeat (5) apply(1, 0, 0, 0, 1);
    apply(1, 1, 1, 0, 1);
    n_vec++;
    if ({if0.restart_counter, if0.in_ready, if0.elem_index, if0.vec_index} !== 5'b10011) begin
      n_err++; $display("FAIL clear_during got %b want 10011",
                        {if0.restart_counter, if0.in_ready, if0.elem_index, if0.vec_index});
    end
    apply(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== expv(k)) begin
        n_err++; $display("FAIL clear_after dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    n_vec++;
    if ({if0.busy, if0.batch_done, if0.elem_index, if0.vec_index} !== 5'b00000) begin
      n_err++; $display("FAIL clear_idle got %b want 00000",
                        {if0.busy, if0.batch_done, if0.elem_index, if0.vec_index});
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    apply(1, 0, 1, 0, 0);
    repeat (3) apply(1, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== expv(k)) begin
        n_err++; $display("FAIL reset_mid dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    n_vec++;
    if ({if0.busy, if0.elem_index, if0.batch_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid_async got %b want 0000", {if0.busy, if0.elem_index, if0.batch_done});
    end
    @(negedge clk);
    rst = 1'b0;
    apply(1, 0, 0, 0, 1);
    n_vec++;
    if ({if0.batch_done, if2.batch_done, if0.busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_mid_nodone got %b want 000", {if0.batch_done, if2.batch_done, if0.busy});
    end
  endtask

  task automatic test_len1();
    bit prev_v = 1'b0;
    pulse_reset();
    apply(1, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      bit v = 1'($urandom_range(0, 1));
      apply(1, 0, 0, 0, v);
      n_vec++;
      if ({if2.batch_done, if2.last_elem, if2.last_vec, if2.restart_counter} !== {prev_v, 1'b1, 1'b1, v}) begin
        n_err++; $display("FAIL len1 cyc%0d got %b want %b", i,
                          {if2.batch_done, if2.last_elem, if2.last_vec, if2.restart_counter},
                          {prev_v, 1'b1, 1'b1, v});
      end
      prev_v = v;
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 8) != 0, ($urandom % 32) == 0, ($urandom % 4) == 0,
            1'($urandom % 2), ($urandom % 4) != 0);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== expv(k)) begin
          n_err++; $display("FAIL random cyc%0d dut%0d got %h want %h", i, k, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_oneshot();
    test_toggle();
    test_en_freeze();
    test_clear();
    test_reset_mid();
    test_len1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
